universal_shift_reg: RTL

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit universal shift register with single-step
// operations and a counted burst mode (IDLE/RUN FSM).
// Optional build macro: USR_PARITY_EN adds a combinational parity output 'par'.
module universal_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    logic [AW-1:0]    amt_clamp;
    logic             burst_ok;
    logic             last_step;

    // Requested burst length saturates at WIDTH steps.
    assign amt_clamp = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;
    // Only the shift/rotate family with a nonzero count turns into a burst.
    assign burst_ok  = (mode >= M_SHL) && (mode <= M_ASR) && (amt_clamp != '0);
    // The step that consumes the final remaining count ends the burst.
    assign last_step = (state_q == RUN) && en && (cnt_q == AW'(1));

    // One application of an operation to the current register value.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] r;
        case (op)
            M_HOLD:  r = cur;
            M_LOAD:  r = din;
            M_SHL:   r = {cur[WIDTH-2:0], sr};
            M_SHR:   r = {sl, cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // FSM state register, asynchronously cleared to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a qualifying start enters RUN, the last step leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && burst_ok) state_d = RUN;
            RUN:     if (last_step)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy reflects the RUN state directly.
    always_comb begin
        busy = (state_q == RUN);
    end

    // Datapath next state: register value, remaining count, latched op, done.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_ok) begin
                        // Latch the burst; the first step happens on the next enabled edge.
                        cnt_d  = amt_clamp;
                        mode_d = mode;
                    end else begin
                        // Degenerate burst: load/clear still act once, ignoring en.
                        done_d = 1'b1;
                        if (mode == M_LOAD || mode == M_CLR)
                            q_d = step_fn(mode, q_q, d, sin_r, sin_l);
                    end
                end else if (en) begin
                    q_d = step_fn(mode, q_q, d, sin_r, sin_l);
                end
            end
            RUN: begin
                // Serial inputs are taken live; mode/d/amount are ignored here.
                if (en) begin
                    q_d    = step_fn(mode_q, q_q, d, sin_r, sin_l);
                    cnt_d  = cnt_q - AW'(1);
                    done_d = (cnt_q == AW'(1));
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            mode_q <= M_HOLD;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign done   = done_q;

`ifdef USR_PARITY_EN
    assign par = ^q_q;
`endif

endmodule
